// File: rtl/song_pkg.sv
// Shared definitions for the song sequencer: default widths and the FSM state
// encoding used by the sequencer top level.
package song_pkg;

  localparam int SONG_BITS = 2;
  localparam int ADDR_BITS = 5;
  localparam int NOTE_W    = 6;
  localparam int DUR_W     = 6;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    LOAD     = 3'd2,
    NEW_NOTE = 3'd3,
    WAIT     = 3'd4,
    PAUSE    = 3'd5,
    END      = 3'd6
  } state_t;

endpackage

// File: rtl/song_sequencer_addr_counter.sv
// Note-address counter for the song sequencer. Clear has priority over
// increment, and the counter saturates at its last value instead of wrapping;
// the sequencer uses is_last to end the song there.
module addr_counter #(
  parameter int ADDR_BITS = song_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 inc,
  output logic [ADDR_BITS-1:0] count,
  output logic                 is_last
);

  assign is_last = (count == {ADDR_BITS{1'b1}});

  // Address register: clear wins, increment only below the last address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {ADDR_BITS{1'b0}};
    end else if (clear) begin
      count <= {ADDR_BITS{1'b0}};
    end else if (inc && !is_last) begin
      count <= count + ADDR_BITS'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Song sequencer: walks the {note, duration} words of the selected song in an
// external ROM, presenting one note at a time and waiting for note_done before
// fetching the next. Supports pause/resume (replays the current note), looping,
// and on-the-fly song change.
module song_sequencer #(
  parameter int SONG_BITS = song_pkg::SONG_BITS,
  parameter int ADDR_BITS = song_pkg::ADDR_BITS,
  parameter int NOTE_W    = song_pkg::NOTE_W,
  parameter int DUR_W     = song_pkg::DUR_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           play,
  input  logic                           loop,
  input  logic [SONG_BITS-1:0]           song,
  input  logic                           note_done,
  output logic [SONG_BITS+ADDR_BITS-1:0] rom_addr,
  input  logic [NOTE_W+DUR_W-1:0]        rom_data,
  output logic                           new_note,
  output logic [NOTE_W-1:0]              note,
  output logic [DUR_W-1:0]               duration,
  output logic                           song_done,
  output logic                           busy
);

  import song_pkg::*;

  state_t                 state;
  state_t                 state_next;
  logic [SONG_BITS-1:0]   song_q;
  logic                   play_q;
  logic                   play_armed;
  logic [ADDR_BITS-1:0]   addr;
  logic                   is_last;
  logic                   addr_clear;
  logic                   addr_inc;
  logic                   load_note;
  logic                   latch_song;
  logic                   song_change;
  logic                   play_rise;
  logic [NOTE_W-1:0]      rom_note;
  logic [DUR_W-1:0]       rom_dur;

  assign rom_note    = rom_data[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur     = rom_data[DUR_W-1:0];
  assign song_change = (song != song_q);
  // A start needs play to have been seen low since reset, so a level held
  // high across reset release is not mistaken for a fresh press.
  assign play_rise   = play && !play_q && play_armed;
  // Address comes straight from registers, so it is glitch-free for the ROM.
  assign rom_addr    = {song_q, addr};

  addr_counter #(
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (addr_clear),
    .inc     (addr_inc),
    .count   (addr),
    .is_last (is_last)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath controls; song change outranks every other move
  always_comb begin
    state_next = state;
    addr_clear = 1'b0;
    addr_inc   = 1'b0;
    load_note  = 1'b0;
    latch_song = 1'b0;
    if ((state != IDLE) && song_change) begin
      latch_song = 1'b1;
      addr_clear = 1'b1;
      state_next = FETCH;
    end else begin
      case (state)
        IDLE: begin
          addr_clear = 1'b1;
          if (play_rise) begin
            latch_song = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
        FETCH: begin
          state_next = LOAD;
        end
        LOAD: begin
          if (rom_dur == {DUR_W{1'b0}}) begin
            state_next = END;
          end else begin
            load_note  = 1'b1;
            state_next = NEW_NOTE;
          end
        end
        NEW_NOTE: begin
          state_next = WAIT;
        end
        WAIT: begin
          if (!play) begin
            state_next = PAUSE;
          end else if (note_done && is_last) begin
            state_next = END;
          end else if (note_done) begin
            addr_inc   = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WAIT;
          end
        end
        PAUSE: begin
          if (play) begin
            state_next = NEW_NOTE;
          end else begin
            state_next = PAUSE;
          end
        end
        END: begin
          addr_clear = 1'b1;
          if (loop && play) begin
            state_next = FETCH;
          end else begin
            state_next = IDLE;
          end
        end
        default: begin
          addr_clear = 1'b1;
          state_next = IDLE;
        end
      endcase
    end
  end

  // Registered outputs, song latch and play edge tracking
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      song_q     <= {SONG_BITS{1'b0}};
      play_q     <= 1'b0;
      play_armed <= 1'b0;
      note       <= {NOTE_W{1'b0}};
      duration   <= {DUR_W{1'b0}};
      new_note   <= 1'b0;
      song_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      play_q <= play;
      if (!play) begin
        play_armed <= 1'b1;
      end
      if (latch_song) begin
        song_q <= song;
      end
      if (load_note) begin
        note     <= rom_note;
        duration <= rom_dur;
      end
      new_note  <= (state_next == NEW_NOTE);
      song_done <= (state_next == END);
      busy      <= (state_next != IDLE);
    end
  end

endmodule
